// File: rtl/mmi64_reg_pkg.sv
// Shared definitions for the MMI64 register responder: opcodes, status codes,
// command/response word layout, FSM state encoding and word pack/unpack helpers.
package mmi64_reg_pkg;

    localparam logic [3:0] OP_NOP   = 4'h0;
    localparam logic [3:0] OP_WRITE = 4'h1;
    localparam logic [3:0] OP_READ  = 4'h2;

    localparam logic [3:0] ST_OK       = 4'h0;
    localparam logic [3:0] ST_ADDR_ERR = 4'h1;
    localparam logic [3:0] ST_OP_ERR   = 4'h2;

    localparam int CODE_LSB = 60;
    localparam int TAG_LSB  = 48;
    localparam int ADDR_LSB = 32;
    localparam int DATA_LSB = 0;
    localparam int CODE_W   = 4;
    localparam int TAG_W    = 12;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    // Opcode or status in code, then tag, address and data.
    typedef struct packed {
        logic [CODE_W-1:0] code;
        logic [TAG_W-1:0]  tag;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } mmi64_word_t;

    function automatic mmi64_word_t unpack_word(input logic [63:0] w);
        mmi64_word_t f;
        f.code = w[CODE_LSB +: CODE_W];
        f.tag  = w[TAG_LSB  +: TAG_W];
        f.addr = w[ADDR_LSB +: ADDR_W];
        f.data = w[DATA_LSB +: DATA_W];
        return f;
    endfunction

    function automatic logic [63:0] pack_word(input mmi64_word_t f);
        logic [63:0] w;
        w = '0;
        w[CODE_LSB +: CODE_W] = f.code;
        w[TAG_LSB  +: TAG_W]  = f.tag;
        w[ADDR_LSB +: ADDR_W] = f.addr;
        w[DATA_LSB +: DATA_W] = f.data;
        return w;
    endfunction

endpackage

// File: rtl/mmi64_reg_bank.sv
// Register bank for the MMI64 responder. Register 0 is a read-only ID word,
// registers 1..NREGS-1 are writable. One write port, one combinational read
// port, and the whole bank exported flat (reg k at [32k+31:32k]).
module mmi64_reg_bank
    import mmi64_reg_pkg::*;
#(
    parameter int          NREGS    = 16,
    parameter logic [31:0] ID_VALUE = 32'h50540001,
    localparam int         AW       = $clog2(NREGS)
)(
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic [AW-1:0]         rd_addr,
    output logic [DATA_W-1:0]     rd_data,
    output logic [32*NREGS-1:0]   regs_flat
);

    logic [NREGS-1:1][31:0] regs_q;

    // Writable registers start at index 1, so a write to address 0 never lands anywhere.
    always_ff @(posedge clock) begin
        if (reset) begin
            for (int k = 1; k < NREGS; k++) regs_q[k] <= '0;
        end else if (wr_en) begin
            for (int k = 1; k < NREGS; k++) begin
                if (wr_addr == AW'(k)) regs_q[k] <= wr_data;
            end
        end
    end

    // Read mux: address 0 and anything unmatched return the ID word.
    always_comb begin
        rd_data = ID_VALUE;
        for (int k = 1; k < NREGS; k++) begin
            if (rd_addr == AW'(k)) rd_data = regs_q[k];
        end
    end

    assign regs_flat[31:0] = ID_VALUE;

    for (genvar g = 1; g < NREGS; g++) begin : g_flat
        assign regs_flat[32*g +: 32] = regs_q[g];
    end

endmodule

// File: rtl/mmi64_reg_responder.sv
// MMI64 register-access responder: accepts one 64-bit command, executes it
// against the local register bank and returns exactly one 64-bit response.
// Optional macro MMI64_RSP_TIMEOUT_EN drops a response that has been stalled
// for TIMEOUT consecutive cycles and counts it as an error.
module mmi64_reg_responder
    import mmi64_reg_pkg::*;
#(
    parameter int          NREGS    = 16,
    parameter logic [31:0] ID_VALUE = 32'h50540001
`ifdef MMI64_RSP_TIMEOUT_EN
    ,
    parameter int          TIMEOUT  = 1024
`endif
)(
    input  logic                 mmi64_clk_i,
    input  logic                 mmi64_reset_i,
    input  logic                 cmd_valid_i,
    output logic                 cmd_ready_o,
    input  logic [63:0]          cmd_data_i,
    output logic                 rsp_valid_o,
    input  logic                 rsp_ready_i,
    output logic [63:0]          rsp_data_o,
    output logic [32*NREGS-1:0]  regs_o,
    output logic [15:0]          err_cnt_o,
    output logic                 busy_o
);

    localparam int          AW         = $clog2(NREGS);
    localparam logic [15:0] NREGS_ADDR = 16'(NREGS);

    state_t       state_q;
    state_t       state_d;
    logic [63:0]  cmd_q;
    logic [63:0]  rsp_q;
    logic [15:0]  err_cnt_q;
    mmi64_word_t  cmd_f;
    mmi64_word_t  rsp_f;
    logic         addr_ok;
    logic         wr_request;
    logic         bank_wr_en;
    logic [31:0]  bank_rd_data;
    logic [3:0]   exec_status;
    logic [31:0]  exec_data;
    logic         rsp_drop;

    assign cmd_f = unpack_word(cmd_q);

    mmi64_reg_bank #(
        .NREGS    (NREGS),
        .ID_VALUE (ID_VALUE)
    ) u_bank (
        .clock     (mmi64_clk_i),
        .reset     (mmi64_reset_i),
        .wr_en     (bank_wr_en),
        .wr_addr   (cmd_f.addr[AW-1:0]),
        .wr_data   (cmd_f.data),
        .rd_addr   (cmd_f.addr[AW-1:0]),
        .rd_data   (bank_rd_data),
        .regs_flat (regs_o)
    );

    // Decode the captured command; an illegal opcode wins over a bad address, and a nop never touches an address.
    always_comb begin
        addr_ok     = (cmd_f.addr < NREGS_ADDR);
        exec_status = ST_OK;
        exec_data   = '0;
        wr_request  = 1'b0;
        case (cmd_f.code)
            OP_NOP: begin
                exec_data = '0;
            end
            OP_WRITE: begin
                if (!addr_ok) begin
                    exec_status = ST_ADDR_ERR;
                end else begin
                    wr_request = 1'b1;
                    exec_data  = (cmd_f.addr == 16'd0) ? ID_VALUE : cmd_f.data;
                end
            end
            OP_READ: begin
                if (!addr_ok) exec_status = ST_ADDR_ERR;
                else          exec_data   = bank_rd_data;
            end
            default: begin
                exec_status = ST_OP_ERR;
            end
        endcase
        rsp_f.code = exec_status;
        rsp_f.tag  = cmd_f.tag;
        rsp_f.addr = cmd_f.addr;
        rsp_f.data = exec_data;
    end

    assign bank_wr_en = wr_request && (state_q == S_EXEC);

`ifdef MMI64_RSP_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] tmo_cnt_q;

    // Count consecutive stalled response cycles; any way out of RESP clears it.
    always_ff @(posedge mmi64_clk_i) begin
        if (mmi64_reset_i || state_q != S_RESP || rsp_ready_i || rsp_drop) tmo_cnt_q <= '0;
        else                                                               tmo_cnt_q <= tmo_cnt_q + 1'b1;
    end

    assign rsp_drop = (state_q == S_RESP) && !rsp_ready_i && (tmo_cnt_q == TW'(TIMEOUT - 1));
`else
    assign rsp_drop = 1'b0;
`endif

    // State register.
    always_ff @(posedge mmi64_clk_i) begin
        if (mmi64_reset_i) state_q <= S_IDLE;
        else               state_q <= state_d;
    end

    // Next state and handshake outputs; exactly one transaction is in flight at a time.
    always_comb begin
        state_d     = state_q;
        cmd_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        busy_o      = 1'b1;
        case (state_q)
            S_IDLE: begin
                cmd_ready_o = 1'b1;
                busy_o      = 1'b0;
                if (cmd_valid_i) state_d = S_EXEC;
            end
            S_EXEC: begin
                state_d = S_RESP;
            end
            S_RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i || rsp_drop) state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Capture the command word on the accept handshake.
    always_ff @(posedge mmi64_clk_i) begin
        if (mmi64_reset_i)                            cmd_q <= '0;
        else if (state_q == S_IDLE && cmd_valid_i)    cmd_q <= cmd_data_i;
    end

    // Register the response in EXEC so it holds steady for the whole of RESP.
    always_ff @(posedge mmi64_clk_i) begin
        if (mmi64_reset_i)              rsp_q <= '0;
        else if (state_q == S_EXEC)     rsp_q <= pack_word(rsp_f);
    end

    // Saturating count of error responses and dropped responses.
    always_ff @(posedge mmi64_clk_i) begin
        if (mmi64_reset_i) begin
            err_cnt_q <= '0;
        end else if (((state_q == S_EXEC) && (exec_status != ST_OK)) || rsp_drop) begin
            if (err_cnt_q != 16'hFFFF) err_cnt_q <= err_cnt_q + 16'd1;
        end
    end

    assign rsp_data_o = rsp_q;
    assign err_cnt_o  = err_cnt_q;

endmodule
